ppu_result_collector: RTL

- Receive-side endpoint for the ppu_top output stream (`out_valid_o`/`result_o`), which has no backpressure.
- Captures every valid result into a credit-protected buffer and re-presents it to a downstream consumer over a valid/ready handshake, tagged with an in-order sequence number.
- Drives `issue_ready_o` back to the operand-issue side, so results can never exceed buffer space.
- Sits between ppu_top and the SoC/host result port.

---
 rtl/ppu_pkg.sv | 14 +
 rtl/ppu_result_fifo.sv | 58 +++++
 rtl/ppu_result_collector.sv | 91 +++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU result path.
package ppu_pkg;

  typedef struct packed {
    logic overflow;
    logic spurious;
  } collector_status_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int clog2_plus1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ppu_result_fifo.sv
// Synchronous FIFO with registered storage; data appears on data_o the cycle after the push.
module ppu_result_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WORD  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [WORD-1:0]                 data_i,
  input  logic                            pop_i,
  output logic [WORD-1:0]                 data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [clog2_plus1(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_plus1(DEPTH);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle frees an entry.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left without reset; an entry is only read after count_q shows it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ppu_result_collector.sv
// Credit-protected capture buffer for the ppu_top result stream, re-presented over valid/ready with a sequence tag.
module ppu_result_collector
  import ppu_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int DEPTH = 8,
  parameter int SEQW  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic                            ppu_valid_i,
  input  logic [WORD-1:0]                 ppu_result_i,
  output logic                            res_valid_o,
  output logic [WORD-1:0]                 res_data_o,
  output logic [SEQW-1:0]                 res_seq_o,
  input  logic                            res_ready_i,
  output logic [clog2_plus1(DEPTH)-1:0]   count_o,
  output logic [clog2_plus1(DEPTH)-1:0]   inflight_o,
  output logic                            overflow_o,
  output logic                            spurious_o
);

  localparam int CW = clog2_plus1(DEPTH);

  logic [CW-1:0]     inflight_q, inflight_d;
  logic [SEQW-1:0]   seq_q, seq_d;
  collector_status_t status_q, status_d;

  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              issue_acc, pop;

  ppu_result_fifo #(.DEPTH(DEPTH), .WORD(WORD)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ppu_valid_i),
    .data_i  (ppu_result_i),
    .pop_i   (res_ready_i),
    .data_o  (res_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Credit is a pure function of registered state so the issue side sees no combinational path.
  assign credit_used   = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue_ready_o = (credit_used < (CW+1)'(DEPTH));
  assign issue_acc     = issue_valid_i & issue_ready_o;

  assign res_valid_o = ~fifo_empty;
  assign pop         = res_valid_o & res_ready_i;
  assign res_seq_o   = seq_q;
  assign count_o     = fifo_count;
  assign inflight_o  = inflight_q;
  assign overflow_o  = status_q.overflow;
  assign spurious_o  = status_q.spurious;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    inflight_d = inflight_q;
    seq_d      = seq_q;
    status_d   = status_q;

    if (issue_acc && !ppu_valid_i) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue_acc && ppu_valid_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end

    if (pop) seq_d = seq_q + 1'b1;

    if (ppu_valid_i && (inflight_q == '0)) status_d.spurious = 1'b1;
    if (ppu_valid_i && fifo_full && !pop)  status_d.overflow = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      seq_q      <= '0;
      status_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      seq_q      <= seq_d;
      status_q   <= status_d;
    end
  end

endmodule
